// File: rtl/wash_phase_timer_if.sv
// Controller <-> wash phase timer bundle: valve/motor commands, level sample, config, status flags.
// Latency: none (plain wires).
// Backpressure: none; all signals are level-sampled every clk.
interface wash_phase_timer_if;
    logic        tick_en;
    logic        motor_on;
    logic        drain_value_on;
    logic        fill_value_on;
    logic [7:0]  level;
    logic [15:0] cfg_cycle_ticks;
    logic [15:0] cfg_spin_ticks;
    logic [15:0] cfg_fill_limit;
    logic        filled;
    logic        drained;
    logic        cycle_timeout;
    logic        spin_timeout;
    logic        fault;

    // Controller side drives commands and config, observes status.
    modport master (
        output tick_en, motor_on, drain_value_on, fill_value_on, level,
               cfg_cycle_ticks, cfg_spin_ticks, cfg_fill_limit,
        input  filled, drained, cycle_timeout, spin_timeout, fault
    );

    // Timer side consumes commands and config, produces status.
    modport slave (
        input  tick_en, motor_on, drain_value_on, fill_value_on, level,
               cfg_cycle_ticks, cfg_spin_ticks, cfg_fill_limit,
        output filled, drained, cycle_timeout, spin_timeout, fault
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Washer phase timing: debounced full/empty flags, wash/spin duration timers, sticky fill watchdog.
// Latency: flags after DEBOUNCE clks; timeouts registered one clk after the terminal tick.
// Backpressure: none; outputs are levels, inputs sampled every clk, no stall path.
module wash_phase_timer #(
    parameter logic [7:0] FULL_LEVEL  = 8'd200,
    parameter logic [7:0] EMPTY_LEVEL = 8'd8,
    parameter int         DEBOUNCE    = 4
) (
    input  logic               clk,
    input  logic               reset,
    wash_phase_timer_if.slave  bus
);

    // A debounce of 0 behaves like 1 (flag follows the very next sample).
    localparam int unsigned DB = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
    localparam int          CW = $clog2(DB + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WASH_RUN  = 3'd1,
        WASH_DONE = 3'd2,
        SPIN_RUN  = 3'd3,
        SPIN_DONE = 3'd4
    } phase_t;

    phase_t        state;
    logic [15:0]   run_cnt;
    logic [15:0]   run_lim;
    logic [15:0]   run_cnt_inc;
    logic [15:0]   wd_cnt;
    logic [15:0]   wd_next;
    logic [CW-1:0] full_cnt;
    logic [CW-1:0] empty_cnt;
    logic          full_now;
    logic          empty_now;
    logic          filled_q;
    logic          drained_q;
    logic          cycle_to_q;
    logic          spin_to_q;
    logic          fault_q;

    assign full_now    = (bus.level >= FULL_LEVEL);
    assign empty_now   = (bus.level <= EMPTY_LEVEL);
    assign run_cnt_inc = run_cnt + 16'd1;

    // Full flag: flips only after DB consecutive samples disagreeing with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filled_q <= 1'b0;
            full_cnt <= '0;
        end else if (full_now == filled_q) begin
            full_cnt <= '0;
        end else if (full_cnt == DB_LAST) begin
            filled_q <= full_now;
            full_cnt <= '0;
        end else begin
            full_cnt <= full_cnt + 1'b1;
        end
    end

    // Empty flag: same rule; the level thresholds keep it exclusive with filled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drained_q <= 1'b0;
            empty_cnt <= '0;
        end else if (empty_now == drained_q) begin
            empty_cnt <= '0;
        end else if (empty_cnt == DB_LAST) begin
            drained_q <= empty_now;
            empty_cnt <= '0;
        end else begin
            empty_cnt <= empty_cnt + 1'b1;
        end
    end

    // Phase FSM: one shared tick counter, limit latched at run entry, exit beats a coincident tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            run_cnt    <= 16'd0;
            run_lim    <= 16'd1;
            cycle_to_q <= 1'b0;
            spin_to_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cycle_to_q <= 1'b0;
                    spin_to_q  <= 1'b0;
                    if (bus.motor_on) begin
                        state   <= WASH_RUN;
                        run_cnt <= 16'd0;
                        run_lim <= (bus.cfg_cycle_ticks == 16'd0) ? 16'd1 : bus.cfg_cycle_ticks;
                    end else if (bus.drain_value_on && drained_q) begin
                        state   <= SPIN_RUN;
                        run_cnt <= 16'd0;
                        run_lim <= (bus.cfg_spin_ticks == 16'd0) ? 16'd1 : bus.cfg_spin_ticks;
                    end
                end
                WASH_RUN: begin
                    if (!bus.motor_on) begin
                        state <= IDLE;
                    end else if (bus.tick_en) begin
                        run_cnt <= run_cnt_inc;
                        if (run_cnt_inc == run_lim) begin
                            state      <= WASH_DONE;
                            cycle_to_q <= 1'b1;
                        end
                    end
                end
                WASH_DONE: begin
                    if (!bus.motor_on) begin
                        state      <= IDLE;
                        cycle_to_q <= 1'b0;
                    end
                end
                SPIN_RUN: begin
                    if (!bus.drain_value_on) begin
                        state <= IDLE;
                    end else if (bus.tick_en) begin
                        run_cnt <= run_cnt_inc;
                        if (run_cnt_inc == run_lim) begin
                            state     <= SPIN_DONE;
                            spin_to_q <= 1'b1;
                        end
                    end
                end
                SPIN_DONE: begin
                    if (!bus.drain_value_on) begin
                        state     <= IDLE;
                        spin_to_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cycle_to_q <= 1'b0;
                    spin_to_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next watchdog count: cleared while not filling or once full, saturating tick count otherwise.
    always_comb begin
        wd_next = wd_cnt;
        if (!bus.fill_value_on || filled_q) begin
            wd_next = 16'd0;
        end else if (bus.tick_en && (wd_cnt != 16'hFFFF)) begin
            wd_next = wd_cnt + 16'd1;
        end
    end

    // Watchdog register and sticky fault; fault raises on the tick that reaches the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt  <= 16'd0;
            fault_q <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if ((bus.cfg_fill_limit != 16'd0) && (wd_next >= bus.cfg_fill_limit)) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus.filled        = filled_q;
    assign bus.drained       = drained_q;
    assign bus.cycle_timeout = cycle_to_q;
    assign bus.spin_timeout  = spin_to_q;
    assign bus.fault         = fault_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer: debounce, wash/spin timing, watchdog, reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: none; fixed step counts bound every wait.
module tb_wash_phase_timer;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    wash_phase_timer_if bus ();

    wash_phase_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_vec++; if (bus.filled !== 1'b0) begin n_err++; $display("FAIL rst_filled got=%0b exp=0", bus.filled); end
        n_vec++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL rst_drained got=%0b exp=0", bus.drained); end
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL rst_cycle got=%0b exp=0", bus.cycle_timeout); end
        n_vec++; if (bus.spin_timeout !== 1'b0) begin n_err++; $display("FAIL rst_spin got=%0b exp=0", bus.spin_timeout); end
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got=%0b exp=0", bus.fault); end
        @(posedge clk); #1;
        reset = 1'b1;
        step(5);
        n_vec++; if (bus.filled !== 1'b0) begin n_err++; $display("FAIL idle_filled got=%0b exp=0", bus.filled); end
        n_vec++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL idle_drained got=%0b exp=0", bus.drained); end
    endtask

    task automatic test_filled_debounce;
        bus.level = 8'd220;
        step(3);
        n_vec++; if (bus.filled !== 1'b0) begin n_err++; $display("FAIL fill_3clk got=%0b exp=0", bus.filled); end
        step(1);
        n_vec++; if (bus.filled !== 1'b1) begin n_err++; $display("FAIL fill_4clk got=%0b exp=1", bus.filled); end
        bus.level = 8'd100;
        step(3);
        n_vec++; if (bus.filled !== 1'b1) begin n_err++; $display("FAIL fill_hold got=%0b exp=1", bus.filled); end
        step(1);
        n_vec++; if (bus.filled !== 1'b0) begin n_err++; $display("FAIL fill_clear got=%0b exp=0", bus.filled); end
        // Glitch: 220, 0, then 220 held -> four further clean samples needed.
        bus.level = 8'd220; step(1);
        bus.level = 8'd0;   step(1);
        bus.level = 8'd220; step(3);
        n_vec++; if (bus.filled !== 1'b0) begin n_err++; $display("FAIL glitch_3 got=%0b exp=0", bus.filled); end
        step(1);
        n_vec++; if (bus.filled !== 1'b1) begin n_err++; $display("FAIL glitch_4 got=%0b exp=1", bus.filled); end
        n_vec++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL glitch_drained got=%0b exp=0", bus.drained); end
        bus.level = 8'd100;
        step(4);
    endtask

    task automatic test_drained;
        bus.level = 8'd5;
        step(3);
        n_vec++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL drain_3clk got=%0b exp=0", bus.drained); end
        step(1);
        n_vec++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL drain_4clk got=%0b exp=1", bus.drained); end
        n_vec++; if (bus.filled !== 1'b0) begin n_err++; $display("FAIL drain_filled got=%0b exp=0", bus.filled); end
    endtask

    task automatic test_wash;
        bus.cfg_cycle_ticks = 16'd3;
        bus.tick_en  = 1'b1;
        bus.motor_on = 1'b1;
        step(3);
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL wash_clk3 got=%0b exp=0", bus.cycle_timeout); end
        step(1);
        n_vec++; if (bus.cycle_timeout !== 1'b1) begin n_err++; $display("FAIL wash_clk4 got=%0b exp=1", bus.cycle_timeout); end
        step(2);
        n_vec++; if (bus.cycle_timeout !== 1'b1) begin n_err++; $display("FAIL wash_hold got=%0b exp=1", bus.cycle_timeout); end
        n_vec++; if (bus.spin_timeout !== 1'b0) begin n_err++; $display("FAIL wash_spin got=%0b exp=0", bus.spin_timeout); end
        bus.motor_on = 1'b0;
        step(1);
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL wash_drop got=%0b exp=0", bus.cycle_timeout); end
    endtask

    task automatic test_early_exit;
        bus.cfg_cycle_ticks = 16'd5;
        bus.motor_on = 1'b1;
        step(3);
        bus.motor_on = 1'b0;
        step(1);
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL early_exit got=%0b exp=0", bus.cycle_timeout); end
        bus.motor_on = 1'b1;
        step(1);
        bus.cfg_cycle_ticks = 16'd1;
        step(4);
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL rerun_4 got=%0b exp=0", bus.cycle_timeout); end
        step(1);
        n_vec++; if (bus.cycle_timeout !== 1'b1) begin n_err++; $display("FAIL rerun_5 got=%0b exp=1", bus.cycle_timeout); end
        bus.motor_on = 1'b0;
        step(1);
    endtask

    task automatic test_exit_wins;
        bus.cfg_cycle_ticks = 16'd1;
        bus.tick_en  = 1'b0;
        bus.motor_on = 1'b1;
        step(1);
        bus.motor_on = 1'b0;
        bus.tick_en  = 1'b1;
        step(1);
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL exit_tick got=%0b exp=0", bus.cycle_timeout); end
        step(1);
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL exit_after got=%0b exp=0", bus.cycle_timeout); end
        // No ticks -> no progress.
        bus.cfg_cycle_ticks = 16'd2;
        bus.tick_en  = 1'b0;
        bus.motor_on = 1'b1;
        step(6);
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL no_tick got=%0b exp=0", bus.cycle_timeout); end
        bus.tick_en = 1'b1;
        step(2);
        n_vec++; if (bus.cycle_timeout !== 1'b1) begin n_err++; $display("FAIL two_tick got=%0b exp=1", bus.cycle_timeout); end
        bus.motor_on = 1'b0;
        step(1);
    endtask

    task automatic test_spin;
        bus.tick_en        = 1'b0;
        bus.cfg_spin_ticks = 16'd0;
        bus.drain_value_on = 1'b1;
        step(1);
        n_vec++; if (bus.spin_timeout !== 1'b0) begin n_err++; $display("FAIL spin_entry got=%0b exp=0", bus.spin_timeout); end
        bus.tick_en = 1'b1;
        step(1);
        n_vec++; if (bus.spin_timeout !== 1'b1) begin n_err++; $display("FAIL spin_zero got=%0b exp=1", bus.spin_timeout); end
        n_vec++; if (bus.cycle_timeout !== 1'b0) begin n_err++; $display("FAIL spin_cycle got=%0b exp=0", bus.cycle_timeout); end
        step(1);
        n_vec++; if (bus.spin_timeout !== 1'b1) begin n_err++; $display("FAIL spin_hold got=%0b exp=1", bus.spin_timeout); end
        bus.drain_value_on = 1'b0;
        step(1);
        n_vec++; if (bus.spin_timeout !== 1'b0) begin n_err++; $display("FAIL spin_drop got=%0b exp=0", bus.spin_timeout); end
        // motor_on wins over a qualifying spin entry.
        bus.cfg_cycle_ticks = 16'd1;
        bus.motor_on       = 1'b1;
        bus.drain_value_on = 1'b1;
        step(2);
        n_vec++; if (bus.cycle_timeout !== 1'b1) begin n_err++; $display("FAIL prio_cycle got=%0b exp=1", bus.cycle_timeout); end
        n_vec++; if (bus.spin_timeout !== 1'b0) begin n_err++; $display("FAIL prio_spin got=%0b exp=0", bus.spin_timeout); end
        bus.motor_on       = 1'b0;
        bus.drain_value_on = 1'b0;
        step(1);
    endtask

    task automatic test_fault;
        bus.level          = 8'd50;
        bus.tick_en        = 1'b1;
        bus.cfg_fill_limit = 16'd0;
        bus.fill_value_on  = 1'b1;
        step(20);
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL wd_disabled got=%0b exp=0", bus.fault); end
        bus.fill_value_on = 1'b0;
        step(1);
        bus.cfg_fill_limit = 16'd10;
        bus.fill_value_on  = 1'b1;
        step(9);
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL wd_9 got=%0b exp=0", bus.fault); end
        step(1);
        n_vec++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL wd_10 got=%0b exp=1", bus.fault); end
        bus.fill_value_on = 1'b0;
        step(3);
        n_vec++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL wd_sticky got=%0b exp=1", bus.fault); end
        n_vec++; if (bus.filled !== 1'b0) begin n_err++; $display("FAIL wd_filled got=%0b exp=0", bus.filled); end
        n_vec++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL wd_drained got=%0b exp=0", bus.drained); end
    endtask

    task automatic test_reset_mid_spin;
        bus.level = 8'd5;
        step(4);
        n_vec++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL rms_drained got=%0b exp=1", bus.drained); end
        bus.cfg_spin_ticks = 16'd10;
        bus.drain_value_on = 1'b1;
        step(4);
        n_vec++; if (bus.spin_timeout !== 1'b0) begin n_err++; $display("FAIL rms_running got=%0b exp=0", bus.spin_timeout); end
        n_vec++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL rms_fault_pre got=%0b exp=1", bus.fault); end
        reset = 1'b0;
        #2;
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL rms_fault got=%0b exp=0", bus.fault); end
        n_vec++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL rms_drain0 got=%0b exp=0", bus.drained); end
        n_vec++; if (bus.spin_timeout !== 1'b0) begin n_err++; $display("FAIL rms_spin0 got=%0b exp=0", bus.spin_timeout); end
        bus.cfg_spin_ticks = 16'd2;
        #1;
        reset = 1'b1;
        step(3);
        n_vec++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL rms_db3 got=%0b exp=0", bus.drained); end
        step(1);
        n_vec++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL rms_db4 got=%0b exp=1", bus.drained); end
        step(2);
        n_vec++; if (bus.spin_timeout !== 1'b0) begin n_err++; $display("FAIL rms_tick1 got=%0b exp=0", bus.spin_timeout); end
        step(1);
        n_vec++; if (bus.spin_timeout !== 1'b1) begin n_err++; $display("FAIL rms_tick2 got=%0b exp=1", bus.spin_timeout); end
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL rms_fault_post got=%0b exp=0", bus.fault); end
    endtask

    // Scenario sequence.
    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.tick_en         = 1'b0;
        bus.motor_on        = 1'b0;
        bus.drain_value_on  = 1'b0;
        bus.fill_value_on   = 1'b0;
        bus.level           = 8'd100;
        bus.cfg_cycle_ticks = 16'd0;
        bus.cfg_spin_ticks  = 16'd0;
        bus.cfg_fill_limit  = 16'd0;
        #3;
        reset = 1'b0;
        test_reset();
        test_filled_debounce();
        test_drained();
        test_wash();
        test_early_exit();
        test_exit_wins();
        test_spin();
        test_fault();
        test_reset_mid_spin();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wash_phase_timer.md
WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 Parameter FULL_LEVEL, default 8'd200: level at/above which the drum is full.
REQ-002 Parameter EMPTY_LEVEL, default 8'd8: level at/below which the drum is empty.
REQ-003 Parameter DEBOUNCE, default 4: consecutive clocks a level condition must hold before its flag changes.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 tick_en  input  1  one-clk timebase strobe; all phase timers count only on tick_en=1.
REQ-007 motor_on  input  1  wash-cycle motor command from the controller.
REQ-008 drain_value_on  input  1  drain valve command from the controller.
REQ-009 fill_value_on  input  1  fill valve command from the controller.
REQ-010 level  input  8  raw unsigned water-level sensor sample.
REQ-011 cfg_cycle_ticks  input  16  wash duration in ticks.
REQ-012 cfg_spin_ticks  input  16  spin duration in ticks.
REQ-013 cfg_fill_limit  input  16  fill watchdog limit in ticks.
REQ-014 filled  output  1  debounced full flag to the controller.
REQ-015 drained  output  1  debounced empty flag to the controller.
REQ-016 cycle_timeout  output  1  wash duration elapsed.
REQ-017 spin_timeout  output  1  spin duration elapsed.
REQ-018 fault  output  1  sticky fill-watchdog fault.

Function
REQ-019 filled SHALL set after level>=FULL_LEVEL on DEBOUNCE consecutive clks, and clear after level<FULL_LEVEL on DEBOUNCE consecutive clks; any opposite sample restarts the debounce count.
REQ-020 drained SHALL follow the same rule using level<=EMPTY_LEVEL; filled and drained are never both 1.
REQ-021 Phase FSM states: IDLE, WASH_RUN, WASH_DONE, SPIN_RUN, SPIN_DONE; one 16-bit tick counter shared by both runs.
REQ-022 IDLE->WASH_RUN on motor_on=1; IDLE->SPIN_RUN on drain_value_on=1 and drained=1 and motor_on=0; motor_on has priority when both qualify.
REQ-023 On entry to a RUN state the counter SHALL clear and the matching cfg value SHALL be captured; cfg changes mid-run have no effect.
REQ-024 In a RUN state the counter increments on tick_en; RUN->DONE on the clk where the incremented count equals the captured limit; a captured limit of 0 is treated as 1.
REQ-025 cycle_timeout=1 exactly while in WASH_DONE; spin_timeout=1 exactly while in SPIN_DONE (registered outputs, asserted the clk after the terminal tick).
REQ-026 WASH_RUN/WASH_DONE->IDLE on motor_on=0; SPIN_RUN/SPIN_DONE->IDLE on drain_value_on=0; leaving RUN early SHALL NOT assert a timeout.
REQ-027 Fill watchdog: separate 16-bit counter clears when fill_value_on=0 or filled=1, else increments on tick_en, saturating at 16'hFFFF.
REQ-028 fault SHALL set when the watchdog count reaches cfg_fill_limit (limit 0 disables) and remain 1 until reset.
REQ-029 fault SHALL NOT alter filled, drained or timeout behaviour.
REQ-030 tick_en coincident with a state-exit condition SHALL be ignored; the exit wins.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, both counters and debounce counts to 0, and filled, drained, cycle_timeout, spin_timeout, fault to 0.
REQ-032 Reset mid-run SHALL discard the run; after release, timing restarts from REQ-022 entry conditions.
REQ-033 After reset release, drained/filled reflect level only after DEBOUNCE clks.

Verification
REQ-034 level=220 held, DEBOUNCE=4 -> filled=1 on 4th clk; level 220,0,220 glitch -> filled stays 0 until 4 further clean samples.
REQ-035 motor_on=1, cfg_cycle_ticks=3, tick_en every clk -> cycle_timeout=1 from clk 4 until clk after motor_on=0.
REQ-036 drain_value_on=1, level=5 debounced, cfg_spin_ticks=0 -> spin_timeout=1 one clk after first tick.
REQ-037 fill_value_on=1, level=50, cfg_fill_limit=10 -> fault=1 after 10 ticks, stays 1 after fill_value_on=0.
REQ-038 motor_on dropped after 2 of 5 ticks -> no cycle_timeout; re-raise -> full 5 ticks required.
REQ-039 reset=0 asserted during SPIN_RUN with fault=1 -> all outputs 0 asynchronously, IDLE on release.
